// File: rtl/lp_audio_pkg.sv
// Shared constants and types for the launchpad audio sample path.
// The address/data widths are also used by the sample BRAM instance.
package lp_audio_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sample_rec_ctrl.sv
// Record/playback sequencer that owns the single port of the sample BRAM.
// Recording writes one sample per strobe; playback reads one sample per
// strobe and presents it two edges after the address is driven.
module sample_rec_ctrl
    import lp_audio_pkg::*;
#(
    parameter int ADDR_W = lp_audio_pkg::ADDR_W,
    parameter int DATA_W = lp_audio_pkg::DATA_W,
    parameter int LOOP   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] mic_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid,
    output logic              recording,
    output logic              playing,
    output logic [ADDR_W:0]   rec_len
);

    // rec_len is one bit wider than the pointers so a completely full
    // memory (2^ADDR_W samples) is representable.
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    ctrl_state_t       state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   rec_len_q;
    // Bit 0: address cycle of an issued read, bit 1: BRAM data cycle.
    logic [1:0]        inflight_q;
    // Set when the final read of a non-looping take is in flight.
    logic              last_q;

    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] play_data_q;
    logic              play_valid_q;
    logic              recording_q;
    logic              playing_q;

    logic              rd_last_d;
    logic              rd_issue_d;
    logic [ADDR_W:0]   rec_len_d;

    // Derived conditions: last address of the take, read issue, length increment.
    always_comb begin
        rd_last_d  = ({1'b0, rd_ptr_q} == (rec_len_q - LEN_ONE));
        rd_issue_d = sample_tick && (inflight_q == 2'b00) && !last_q;
        rec_len_d  = rec_len_q + LEN_ONE;
    end

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rec_len_q    <= '0;
            inflight_q   <= 2'b00;
            last_q       <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            play_data_q  <= '0;
            play_valid_q <= 1'b0;
            recording_q  <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            // Write strobe and valid pulse are single-cycle by default.
            ram_we_q     <= 1'b0;
            play_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Record beats play when both are requested together.
                    if (rec_start) begin
                        state_q     <= S_RECORD;
                        recording_q <= 1'b1;
                        wr_ptr_q    <= '0;
                        rec_len_q   <= '0;
                    end else if (play_start && (rec_len_q != '0)) begin
                        state_q    <= S_PLAY;
                        playing_q  <= 1'b1;
                        rd_ptr_q   <= '0;
                        inflight_q <= 2'b00;
                        last_q     <= 1'b0;
                    end
                end

                S_RECORD: begin
                    // A stop coincident with a tick wins; that tick is lost.
                    if (rec_stop) begin
                        state_q     <= S_IDLE;
                        recording_q <= 1'b0;
                    end else if (sample_tick) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= wr_ptr_q;
                        ram_wdata_q <= mic_data;
                        wr_ptr_q    <= wr_ptr_q + 1'b1;
                        rec_len_q   <= rec_len_d;
                        // Memory full: stop rather than overwrite the start.
                        if (rec_len_d == LEN_FULL) begin
                            state_q     <= S_IDLE;
                            recording_q <= 1'b0;
                        end
                    end
                end

                S_PLAY: begin
                    if (play_stop) begin
                        // Abandon any read in flight without a valid pulse.
                        state_q    <= S_IDLE;
                        playing_q  <= 1'b0;
                        inflight_q <= 2'b00;
                        last_q     <= 1'b0;
                    end else begin
                        inflight_q <= {inflight_q[0], rd_issue_d};
                        if (rd_issue_d) begin
                            ram_addr_q <= rd_ptr_q;
                            if (rd_last_d) begin
                                rd_ptr_q <= '0;
                                last_q   <= (LOOP == 0);
                            end else begin
                                rd_ptr_q <= rd_ptr_q + 1'b1;
                            end
                        end
                        if (inflight_q[1]) begin
                            play_data_q  <= ram_rdata;
                            play_valid_q <= 1'b1;
                            // Non-looping take ends as its last sample is presented.
                            if (last_q) begin
                                state_q   <= S_IDLE;
                                playing_q <= 1'b0;
                                last_q    <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    recording_q <= 1'b0;
                    playing_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign play_data  = play_data_q;
    assign play_valid = play_valid_q;
    assign recording  = recording_q;
    assign playing    = playing_q;
    assign rec_len    = rec_len_q;

endmodule

// File: tb/tb_sample_rec_ctrl.sv
// Scoreboard bench for sample_rec_ctrl: three instances cover the default
// looping build, a non-looping build and a 16-entry build for the full case.
module tb_sample_rec_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       rec_start = 1'b0, rec_stop = 1'b0, play_start = 1'b0, play_stop = 1'b0;
    logic       tick = 1'b0;
    logic [9:0] mic = '0;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    logic [27:0] exp_wr[$];
    logic [9:0]  exp_rd[$];

    // Instance A: 18-bit address, looping
    logic        a_we, a_pv, a_rec, a_play;
    logic [17:0] a_addr;
    logic [9:0]  a_wdata, a_rdata, a_pd;
    logic [18:0] a_len;
    // Instance B: 8-bit address, non-looping
    logic        b_we, b_pv, b_rec, b_play;
    logic [7:0]  b_addr;
    logic [9:0]  b_wdata, b_rdata, b_pd;
    logic [8:0]  b_len;
    // Instance C: 4-bit address, looping
    logic        c_we, c_pv, c_rec, c_play;
    logic [3:0]  c_addr;
    logic [9:0]  c_wdata, c_rdata, c_pd;
    logic [4:0]  c_len;

    sample_rec_ctrl #(.ADDR_W(18), .DATA_W(10), .LOOP(1)) dut_a (
        .Clk(clk), .Reset(rst), .rec_start(rec_start), .rec_stop(rec_stop),
        .play_start(play_start), .play_stop(play_stop), .sample_tick(tick),
        .mic_data(mic), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata),
        .ram_rdata(a_rdata), .play_data(a_pd), .play_valid(a_pv),
        .recording(a_rec), .playing(a_play), .rec_len(a_len));

    sample_rec_ctrl #(.ADDR_W(8), .DATA_W(10), .LOOP(0)) dut_b (
        .Clk(clk), .Reset(rst), .rec_start(rec_start), .rec_stop(rec_stop),
        .play_start(play_start), .play_stop(play_stop), .sample_tick(tick),
        .mic_data(mic), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
        .ram_rdata(b_rdata), .play_data(b_pd), .play_valid(b_pv),
        .recording(b_rec), .playing(b_play), .rec_len(b_len));

    sample_rec_ctrl #(.ADDR_W(4), .DATA_W(10), .LOOP(1)) dut_c (
        .Clk(clk), .Reset(rst), .rec_start(rec_start), .rec_stop(rec_stop),
        .play_start(play_start), .play_stop(play_stop), .sample_tick(tick),
        .mic_data(mic), .ram_we(c_we), .ram_addr(c_addr), .ram_wdata(c_wdata),
        .ram_rdata(c_rdata), .play_data(c_pd), .play_valid(c_pv),
        .recording(c_rec), .playing(c_play), .rec_len(c_len));

    // Single-port BRAM models with registered read on non-write cycles
    logic [9:0] mem_a [0:262143];
    logic [9:0] mem_b [0:255];
    logic [9:0] mem_c [0:15];
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata; else a_rdata <= mem_a[a_addr];
        if (b_we) mem_b[b_addr] <= b_wdata; else b_rdata <= mem_b[b_addr];
        if (c_we) mem_c[c_addr] <= c_wdata; else c_rdata <= mem_c[c_addr];
    end

    // Outputs of the instance currently under observation
    logic        m_we, m_pv;
    logic [17:0] m_addr;
    logic [9:0]  m_wdata, m_pd;
    always_comb begin
        m_we = a_we; m_pv = a_pv; m_addr = a_addr; m_wdata = a_wdata; m_pd = a_pd;
        if (sel == 1) begin
            m_we = b_we; m_pv = b_pv; m_addr = {10'b0, b_addr}; m_wdata = b_wdata; m_pd = b_pd;
        end else if (sel == 2) begin
            m_we = c_we; m_pv = c_pv; m_addr = {14'b0, c_addr}; m_wdata = c_wdata; m_pd = c_pd;
        end
    end

    // Scoreboard monitor: every write and every play_valid must match a queued expectation
    initial begin
        logic        prev_we;
        logic [27:0] ew;
        logic [9:0]  er;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 1'b0;
            end else begin
                if (m_we) begin
                    n_checks++;
                    if (prev_we) begin
                        n_errors++;
                        $display("FAIL we_back_to_back: got ram_we high 2 cycles, required single-cycle");
                    end
                    n_checks++;
                    if (exp_wr.size() == 0) begin
                        n_errors++;
                        $display("FAIL write_unexpected: got addr=%0d data=%0d, required no write", m_addr, m_wdata);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({m_addr, m_wdata} !== ew) begin
                            n_errors++;
                            $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                     m_addr, m_wdata, ew[27:10], ew[9:0]);
                        end else begin
                            $display("write addr=%0d data=%0d ok", m_addr, m_wdata);
                        end
                    end
                end
                if (m_pv) begin
                    n_checks++;
                    if (exp_rd.size() == 0) begin
                        n_errors++;
                        $display("FAIL play_unexpected: got play_data=%0d, required no play_valid", m_pd);
                    end else begin
                        er = exp_rd.pop_front();
                        if (m_pd !== er) begin
                            n_errors++;
                            $display("FAIL play_data: got %0d, required %0d", m_pd, er);
                        end else begin
                            $display("play data=%0d ok", m_pd);
                        end
                    end
                end
                prev_we = m_we;
            end
        end
    end

    task automatic drive(input logic rs, input logic rp, input logic ps, input logic pp,
                         input logic tk, input logic [9:0] d);
        rec_start = rs; rec_stop = rp; play_start = ps; play_stop = pp; tick = tk; mic = d;
        @(posedge clk); #1;
        rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0;
        tick = 1'b0; mic = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        sel = s;
        idle(2);
        rst = 1'b0;
    endtask

    // Records n samples base, base+1, ... with 3-clock tick spacing.
    task automatic record_take(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({18'(i), 10'(base + i)});
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(base + i));
            idle(2);
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        @(negedge clk);
        n_checks++;
        if ({a_we, a_addr, a_wdata, a_pd, a_pv, a_rec, a_play, a_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_a: got we=%0d addr=%0d wd=%0d pd=%0d pv=%0d rec=%0d play=%0d len=%0d, required all 0",
                     a_we, a_addr, a_wdata, a_pd, a_pv, a_rec, a_play, a_len);
        end
        n_checks++;
        if ({b_rec, b_play, b_len, c_rec, c_play, c_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_bc: got b_len=%0d c_len=%0d, required 0", b_len, c_len);
        end
        $display("reset checked");
    endtask

    task automatic test_record_play();
        do_reset(0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_rec !== 1'b1) begin n_errors++; $display("FAIL rec_flag: got %0d, required 1", a_rec); end
        record_take(5, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_rec !== 1'b0 || a_len !== 19'd5) begin
            n_errors++; $display("FAIL rec_stop_len: got rec=%0d len=%0d, required rec=0 len=5", a_rec, a_len);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_play !== 1'b1) begin n_errors++; $display("FAIL play_flag: got %0d, required 1", a_play); end
        for (int k = 0; k < 5; k++) begin
            exp_rd.push_back(10'(k + 1));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
            @(negedge clk);
            n_checks++;
            if (a_addr !== 18'(k) || a_we !== 1'b0) begin
                n_errors++; $display("FAIL read_addr: got addr=%0d we=%0d, required addr=%0d we=0", a_addr, a_we, k);
            end
            @(negedge clk);
            n_checks++;
            if (a_pv !== 1'b0) begin n_errors++; $display("FAIL read_early: got play_valid=1 at t+2, required 0"); end
            @(negedge clk);
            n_checks++;
            if (a_pv !== 1'b1 || a_pd !== 10'(k + 1)) begin
                n_errors++; $display("FAIL read_latency: got pv=%0d pd=%0d at t+3, required pv=1 pd=%0d", a_pv, a_pd, k + 1);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        idle(3);
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_errors++; $display("FAIL record_play_drain: got %0d/%0d pending, required 0", exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic test_loop();
        do_reset(0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        record_take(3, 7);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        for (int k = 0; k < 7; k++) begin
            exp_rd.push_back(10'(7 + (k % 3)));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
            idle(3);
        end
        n_checks++;
        if (a_play !== 1'b1) begin n_errors++; $display("FAIL loop_playing: got %0d, required 1", a_play); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        idle(3);
        n_checks++;
        if (exp_rd.size() != 0) begin
            n_errors++; $display("FAIL loop_drain: got %0d pending, required 0", exp_rd.size());
        end
    endtask

    task automatic test_no_loop();
        do_reset(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        record_take(3, 7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        n_checks++;
        if (b_len !== 9'd3) begin n_errors++; $display("FAIL noloop_len: got %0d, required 3", b_len); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        for (int k = 0; k < 3; k++) begin
            exp_rd.push_back(10'(7 + k));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (b_play !== 1'b1) begin n_errors++; $display("FAIL noloop_play_early: got playing=%0d, required 1", b_play); end
            @(negedge clk);
            if (k == 2) begin
                n_checks++;
                if (b_pv !== 1'b1 || b_play !== 1'b0) begin
                    n_errors++; $display("FAIL noloop_end: got pv=%0d playing=%0d, required pv=1 playing=0", b_pv, b_play);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        idle(4);
        n_checks++;
        if (b_play !== 1'b0 || exp_rd.size() != 0) begin
            n_errors++; $display("FAIL noloop_idle: got playing=%0d pending=%0d, required 0/0", b_play, exp_rd.size());
        end
    endtask

    task automatic test_full();
        do_reset(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_wr.push_back({18'(i), 10'(100 + i)});
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(100 + i));
            if (i == 15) begin
                @(negedge clk);
                n_checks++;
                if (c_rec !== 1'b0 || c_len !== 5'd16) begin
                    n_errors++; $display("FAIL full_auto_idle: got rec=%0d len=%0d, required rec=0 len=16", c_rec, c_len);
                end
            end
            idle(2);
        end
        n_checks++;
        if (c_len !== 5'd16 || exp_wr.size() != 0) begin
            n_errors++; $display("FAIL full_final: got len=%0d pending=%0d, required len=16 pending=0", c_len, exp_wr.size());
        end
    endtask

    task automatic test_priority();
        do_reset(0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        record_take(2, 20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd99);
        @(negedge clk);
        n_checks++;
        if (a_rec !== 1'b0 || a_len !== 19'd2) begin
            n_errors++; $display("FAIL stop_vs_tick: got rec=%0d len=%0d, required rec=0 len=2", a_rec, a_len);
        end
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_play !== 1'b0) begin n_errors++; $display("FAIL play_stop: got playing=%0d, required 0", a_play); end
        idle(4);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_rec !== 1'b1 || a_play !== 1'b0 || a_len !== 19'd0) begin
            n_errors++; $display("FAIL rec_wins: got rec=%0d play=%0d len=%0d, required 1/0/0", a_rec, a_play, a_len);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        idle(2);
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_errors++; $display("FAIL priority_drain: got %0d/%0d pending, required 0", exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic test_ignored();
        do_reset(0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_play !== 1'b0) begin n_errors++; $display("FAIL play_empty: got playing=%0d, required 0", a_play); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        record_take(3, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        n_checks++;
        if (a_rec !== 1'b0 || a_play !== 1'b1 || a_len !== 19'd3) begin
            n_errors++; $display("FAIL rec_in_play: got rec=%0d play=%0d len=%0d, required 0/1/3", a_rec, a_play, a_len);
        end
        exp_rd.push_back(10'd10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        idle(4);
        exp_rd.push_back(10'd11);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        idle(2);
        n_checks++;
        if (exp_rd.size() != 0) begin
            n_errors++; $display("FAIL ignored_drain: got %0d pending, required 0", exp_rd.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        record_take(4, 30);
        n_checks++;
        if (a_len !== 19'd4 || exp_wr.size() != 0) begin
            n_errors++; $display("FAIL mid_len: got len=%0d pending=%0d, required 4/0", a_len, exp_wr.size());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_we, a_addr, a_wdata, a_pd, a_pv, a_rec, a_play, a_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got we=%0d addr=%0d wd=%0d rec=%0d len=%0d, required all 0",
                     a_we, a_addr, a_wdata, a_rec, a_len);
        end
    endtask

    initial begin
        test_reset();
        test_record_play();
        test_loop();
        test_no_loop();
        test_full();
        test_priority();
        test_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sample_rec_ctrl.md
# sample_rec_ctrl

Record/playback sequencer for the user sample store. It owns the single port of the 262144×10 sample BRAM (`big_ram`), and writes incoming 10-bit audio samples on each sample strobe while recording. During playback it reads them back in order, one per strobe, with optional looping. It sits between the audio codec sample path and the BRAM, and the launchpad button logic drives its start/stop pulses.

## Interface
- `ADDR_W`, 18, BRAM address width; depth = 2^ADDR_W.
- `DATA_W`, 10, sample width.
- `LOOP`, 1, 1 = playback wraps to address 0; 0 = playback stops after the last sample.

- `Clk` in 1: single clock for the block and the BRAM.
- `Reset` in 1: synchronous, active-high.
- `rec_start` in 1: one-cycle pulse, begin a new recording.
- `rec_stop` in 1: one-cycle pulse, end the recording.
- `play_start` in 1: one-cycle pulse, begin playback.
- `play_stop` in 1: one-cycle pulse, end playback.
- `sample_tick` in 1: one-cycle audio-rate strobe.
- `mic_data` in DATA_W: sample to record, valid while `sample_tick` is high.
- `ram_we` out 1: BRAM write enable.
- `ram_addr` out ADDR_W: BRAM address.
- `ram_wdata` out DATA_W: BRAM write data.
- `ram_rdata` in DATA_W: BRAM registered read data, valid 1 clock after a non-write cycle.
- `play_data` out DATA_W: played-back sample.
- `play_valid` out 1: one-cycle qualifier for `play_data`.
- `recording` out 1: high in RECORD.
- `playing` out 1: high in PLAY.
- `rec_len` out ADDR_W+1: number of stored samples, 0..2^ADDR_W.

## Operation
- States are IDLE, RECORD and PLAY. All outputs are registered.
- **IDLE transitions**
  - `rec_start` goes to RECORD. Wr_ptr←0 and `rec_len`←0, so the previous take is discarded.
  - `play_start` with `rec_len`>0 goes to PLAY with rd_ptr←0.
  - `play_start` with `rec_len`=0 is ignored.
  - When `rec_start` and `play_start` arrive together, record wins.
  - `sample_tick` is ignored in IDLE.
- **RECORD**
  - Each `sample_tick` registers `ram_we`=1, `ram_addr`=wr_ptr and `ram_wdata`=`mic_data`, then does wr_ptr++ and `rec_len`++.
  - `rec_stop` goes to IDLE and `rec_len` is kept. `rec_stop` takes priority over a coincident tick, so that tick is not written.
  - On the write that makes `rec_len`=2^ADDR_W, the block auto-returns to IDLE. The memory is full and there is no wrap.
  - `play_start` and `rec_start` are ignored in RECORD.
- **PLAY**
  - Each `sample_tick` registers `ram_addr`=rd_ptr with `ram_we`=0 and issues a read.
  - Two edges later, `play_data`←`ram_rdata` and `play_valid` pulses.
  - Wrap rule: when rd_ptr = `rec_len`−1 at issue, the next rd_ptr depends on `LOOP`.
    - `LOOP`=1: rd_ptr←0.
    - `LOOP`=0: go to IDLE once that last read's `play_valid` has been emitted.
  - Ticks arriving while a read is in flight (the 2 cycles after issue) are dropped.
  - `play_stop` goes to IDLE immediately. Any in-flight read is discarded and no `play_valid` is produced for it.
  - `rec_start` and `play_start` are ignored in PLAY.
- Pointers are ADDR_W bits and `rec_len` is ADDR_W+1 bits. Compare `rec_len`−1 in ADDR_W+1 bits.

## Timing
- **Reset values:** `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `play_data`=0, `play_valid`=0, `recording`=0, `playing`=0, `rec_len`=0, state=IDLE.
- Reset mid-operation aborts immediately and the take is lost.
- **Write latency:** tick high in cycle t gives `ram_we`=1 during cycle t+1 only, and the BRAM commits at the end of t+1.
- **Read latency:** tick in cycle t gives the address in t+1, `ram_rdata` in t+2, and `play_valid` high in cycle t+3.
- `ram_we` is never high for 2 consecutive cycles.
- `play_valid` is never high outside PLAY, except for the final-sample pulse when `LOOP`=0.
- Start/stop pulses take effect on the next edge, so `recording`/`playing` change 1 cycle after the pulse.
- Minimum `sample_tick` spacing is 3 clocks; the codec rate is far below this.

## Structure
- Package `lp_audio_pkg` holds:
  - `ADDR_W` and `DATA_W` constants, shared with the BRAM instance;
  - the `ctrl_state_t` enum {S_IDLE, S_RECORD, S_PLAY}.
- The block is a single module and no sub-module is needed.
- The in-flight read tracker is a 2-bit shift register inside it.

## Test plan
- **Record then play:** Reset, `rec_start`, 5 ticks with `mic_data`=1..5, `rec_stop`. Expect writes at addr 0..4, `rec_len`=5. Then `play_start` and 5 ticks: `play_valid` 3 cycles after each tick with data 1..5.
- **Loop:** `LOOP`=1, `rec_len`=3 (data 7,8,9), 7 play ticks. Expect 7,8,9,7,8,9,7. With `LOOP`=0, the sequence is 7,8,9, then `playing` drops after the third `play_valid`.
- **Full:** `ADDR_W`=4, record 20 ticks. Expect exactly 16 writes, `rec_len`=16, auto-return to IDLE after the 16th write.
- **Stop/edge priority:** `play_stop` one cycle after a play tick gives no `play_valid`. `rec_stop` coincident with a tick gives no write. `rec_start`+`play_start` together give RECORD.
- **Ignored events:** `play_start` with `rec_len`=0 stays IDLE. `rec_start` during PLAY has no effect. A tick 1 cycle after a play tick is dropped, so there is no second read.
- **Reset mid-record:** after 4 writes, `Reset` gives all outputs at reset values and `rec_len`=0.
